video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_pkg.sv | 25 ++
 rtl/video_timing_gen.sv | 84 ++++++++
 tb/tb_video_timing_gen.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video timing definitions: 720p defaults, derived totals, count widths.
package video_pkg;
  localparam int ACTIVE_H_DEF = 1280;
  localparam int H_FP_DEF     = 110;
  localparam int H_SYNC_DEF   = 40;
  localparam int H_BP_DEF     = 220;
  localparam int ACTIVE_V_DEF = 720;
  localparam int V_FP_DEF     = 5;
  localparam int V_SYNC_DEF   = 5;
  localparam int V_BP_DEF     = 20;

  localparam int H_TOTAL = ACTIVE_H_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = ACTIVE_V_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_W  = 11;
  localparam int V_W  = 10;
  localparam int FC_W = 6;

  // Per-position qualifiers that travel with the h/v stream downstream.
  typedef struct packed {
    logic active_draw;
    logic h_sync;
    logic v_sync;
  } vid_flags_t;
endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v position, active/sync flags, frame pulse and
// frame counter. Every output is registered from the same next position so
// the whole bundle changes together on one edge.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int ACTIVE_H = ACTIVE_H_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int ACTIVE_V = ACTIVE_V_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  output logic [H_W-1:0]  h_count,
  output logic [V_W-1:0]  v_count,
  output logic            active_draw,
  output logic            h_sync,
  output logic            v_sync,
  output logic            new_frame,
  output logic [FC_W-1:0] frame_count
);
  localparam int HT = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int VT = ACTIVE_V + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_LAST = H_W'(HT - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(ACTIVE_H);
  localparam logic [H_W-1:0] HS_ON  = H_W'(ACTIVE_H + H_FP);
  localparam logic [H_W-1:0] HS_OFF = H_W'(ACTIVE_H + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST = V_W'(VT - 1);
  localparam logic [V_W-1:0] V_ACT  = V_W'(ACTIVE_V);
  localparam logic [V_W-1:0] VS_ON  = V_W'(ACTIVE_V + V_FP);
  localparam logic [V_W-1:0] VS_OFF = V_W'(ACTIVE_V + V_FP + V_SYNC);

  logic [H_W-1:0] h_nxt;
  logic [V_W-1:0] v_nxt;
  vid_flags_t     flags_nxt;
  logic           nf_nxt;

  // Next raster position: horizontal wrap carries into vertical, which wraps per frame.
  always_comb begin
    h_nxt = h_count + 1'b1;
    v_nxt = v_count;
    if (h_count == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end
  end

  // Flags decoded from the next position so they register alongside it, never a cycle late.
  always_comb begin
    flags_nxt.active_draw = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    flags_nxt.h_sync      = (h_nxt >= HS_ON) && (h_nxt < HS_OFF);
    flags_nxt.v_sync      = (v_nxt >= VS_ON) && (v_nxt < VS_OFF);
    nf_nxt                = (h_nxt == H_ACT) && (v_nxt == V_ACT);
  end

  // Reset parks on the last position so the first enabled step lands on (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_count     <= H_LAST;
      v_count     <= V_LAST;
      active_draw <= 1'b0;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      new_frame   <= 1'b0;
      frame_count <= '0;
    end else if (enable) begin
      h_count     <= h_nxt;
      v_count     <= v_nxt;
      active_draw <= flags_nxt.active_draw;
      h_sync      <= flags_nxt.h_sync;
      v_sync      <= flags_nxt.v_sync;
      new_frame   <= nf_nxt;
      if (nf_nxt) frame_count <= frame_count + 1'b1;
    end else begin
      new_frame   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a shrunk raster so whole frames fit in a
// short run. The reference model tracks a linear pixel index within the frame
// and derives position and flags by division/modulo.
module tb_video_timing_gen;
  localparam int AH = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int AV = 10, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = AH + HFP + HSW + HBP;   // 28
  localparam int VT = AV + VFP + VSW + VBP;   // 17
  localparam int FRAME  = HT * VT;            // 476
  localparam int NF_IDX = AV * HT + AH;

  logic        clk = 0, rst = 0, enable = 0;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        active_draw, h_sync, v_sync, new_frame;
  logic [5:0]  frame_count;

  int total = 0, bad = 0;
  int m_idx, m_fc;
  logic m_nf;

  video_timing_gen #(
    .ACTIVE_H(AH), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .ACTIVE_V(AV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .h_count(h_count), .v_count(v_count), .active_draw(active_draw),
    .h_sync(h_sync), .v_sync(v_sync), .new_frame(new_frame),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  wire [30:0] dut_vec = {h_count, v_count, active_draw, h_sync, v_sync, new_frame, frame_count};

  function automatic int mh(); return m_idx % HT; endfunction
  function automatic int mv(); return m_idx / HT; endfunction

  function automatic logic [30:0] exp_vec();
    int h, v;
    h = mh(); v = mv();
    return {11'(h), 10'(v), (h < AH) && (v < AV),
            (h >= AH + HFP) && (h < AH + HFP + HSW),
            (v >= AV + VFP) && (v < AV + VFP + VSW),
            m_nf, 6'(m_fc)};
  endfunction

  task automatic model_reset();
    m_idx = FRAME - 1; m_fc = 0; m_nf = 0;
  endtask

  task automatic step(input logic en);
    @(negedge clk); enable = en;
    @(posedge clk); #1;
    if (en) begin
      m_idx = (m_idx + 1) % FRAME;
      m_nf  = (m_idx == NF_IDX);
      if (m_nf) m_fc = (m_fc + 1) % 64;
    end else m_nf = 0;
  endtask

  task automatic goto(input int h, input int v);
    for (int i = 0; i < 2 * FRAME && !(mh() == h && mv() == v); i++) step(1'b1);
  endtask

  task automatic test_reset();
    rst = 0; enable = 1; model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec()); end
    @(negedge clk); enable = 0; rst = 1;
  endtask

  task automatic test_first_line();
    step(1'b1);
    total++;
    if ({h_count, v_count, active_draw} !== {11'd0, 10'd0, 1'b1}) begin
      bad++; $display("FAIL first_edge got=%0d,%0d,%b exp=0,0,1", h_count, v_count, active_draw);
    end
    repeat (AH - 1) step(1'b1);
    step(1'b1);
    total++;
    if ({h_count, v_count, active_draw} !== {11'(AH), 10'd0, 1'b0}) begin
      bad++; $display("FAIL end_active got=%0d,%0d,%b exp=%0d,0,0", h_count, v_count, active_draw, AH);
    end
  endtask

  task automatic test_line_wrap();
    int hs_cnt, hs_first;
    goto(HT - 1, 5);
    total++;
    if ({h_count, v_count} !== {11'(HT - 1), 10'd5}) begin
      bad++; $display("FAIL pre_wrap got=%0d,%0d exp=%0d,5", h_count, v_count, HT - 1);
    end
    step(1'b1);
    total++;
    if ({h_count, v_count} !== {11'd0, 10'd6}) begin
      bad++; $display("FAIL line_wrap got=%0d,%0d exp=0,6", h_count, v_count);
    end
    hs_cnt = 0; hs_first = -1;
    for (int i = 0; i < HT; i++) begin
      if (h_sync === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(h_count);
      end
      step(1'b1);
    end
    total++;
    if (hs_cnt != HSW) begin bad++; $display("FAIL hsync_width got=%0d exp=%0d", hs_cnt, HSW); end
    total++;
    if (hs_first != AH + HFP) begin bad++; $display("FAIL hsync_start got=%0d exp=%0d", hs_first, AH + HFP); end
  endtask

  task automatic test_frame();
    int n, vs_cnt, vs_err;
    n = 0;
    while (new_frame !== 1'b1 && n < 2 * FRAME) begin step(1'b1); n++; end
    total++;
    if ({new_frame, h_count, v_count} !== {1'b1, 11'(AH), 10'(AV)}) begin
      bad++; $display("FAIL nf_pos got=%b,%0d,%0d exp=1,%0d,%0d", new_frame, h_count, v_count, AH, AV);
    end
    n = 0; vs_cnt = 0; vs_err = 0;
    do begin
      step(1'b1); n++;
      if (v_sync === 1'b1) vs_cnt++;
      if (v_sync !== ((int'(v_count) >= AV + VFP) && (int'(v_count) < AV + VFP + VSW))) vs_err++;
    end while (new_frame !== 1'b1 && n < 2 * FRAME);
    total++;
    if (n != FRAME) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", n, FRAME); end
    total++;
    if (vs_cnt != VSW * HT || vs_err != 0) begin
      bad++; $display("FAIL vsync_lines got=%0d err=%0d exp=%0d err=0", vs_cnt, vs_err, VSW * HT);
    end
  endtask

  task automatic test_enable_gating();
    logic [30:0] held;
    int fc0;
    goto(AH - 2, AV);
    fc0 = m_fc;
    step(1'b1);
    held = dut_vec;
    for (int i = 0; i < 2; i++) begin
      step(1'b0);
      total++;
      if (dut_vec !== held) begin bad++; $display("FAIL gate_hold got=%h exp=%h", dut_vec, held); end
    end
    step(1'b1);
    total++;
    if ({new_frame, h_count, v_count, frame_count} !== {1'b1, 11'(AH), 10'(AV), 6'((fc0 + 1) % 64)}) begin
      bad++; $display("FAIL gate_pulse got=%b,%0d,%0d,%0d exp=1,%0d,%0d,%0d",
                      new_frame, h_count, v_count, frame_count, AH, AV, (fc0 + 1) % 64);
    end
    step(1'b1);
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL gate_after got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_async_reset();
    logic [30:0] rv;
    goto(8, 5);
    @(posedge clk); #3;
    rst = 0;
    #1;
    model_reset();
    rv = exp_vec();
    total++;
    if (dut_vec !== rv) begin bad++; $display("FAIL async_reset got=%h exp=%h", dut_vec, rv); end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== rv) begin bad++; $display("FAIL reset_hold got=%h exp=%h", dut_vec, rv); end
    @(negedge clk); enable = 0; rst = 1;
    step(1'b1);
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL post_reset got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_fc_wrap();
    int pulses, maxfc, n;
    pulses = 0; maxfc = 0; n = 0;
    while (pulses < 64 && n < 65 * FRAME) begin
      step(1'b1); n++;
      if (new_frame === 1'b1) pulses++;
      if (int'(frame_count) > maxfc) maxfc = int'(frame_count);
    end
    total++;
    if (pulses != 64 || maxfc != 63 || frame_count !== 6'd0) begin
      bad++; $display("FAIL fc_wrap got=p%0d max%0d fc%0d exp=p64 max63 fc0", pulses, maxfc, frame_count);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        if (errs++ < 10) $display("FAIL random_step%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_line_wrap();
    test_frame();
    test_enable_gating();
    test_random();
    test_async_reset();
    test_fc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
